enet_rx_port: RTL

Memory-mapped Ethernet receive port for the CPU54 RX design. It captures MII receive nibbles, strips the preamble and SFD, and assembles bytes. Bytes are buffered with end-of-frame markers in a FIFO. The CPU drains the FIFO through the `enet_cs` select that the address decoder asserts for address 0x10810004.

---
 rtl/enet_rx_port.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/enet_rx_port.sv
`default_nettype none
// ============================================================================
// Module   : enet_rx_port
// Purpose  : Memory-mapped Ethernet MII receive port. Strips preamble/SFD,
//            assembles bytes, holds them in a short delay line and buffers
//            them with end-of-frame markers in a FIFO drained by the CPU.
// Options  : ENET_RX_CRC_STRIP_EN - 5-byte delay line so the 4 FCS bytes are
//            never pushed and eof lands on the last payload byte.
// Revision : 1.0 - initial release
// ============================================================================
module enet_rx_port #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enet_cs,
    input  logic        sig_r,
    input  logic        sig_w,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_dv,
    input  logic [3:0]  rxd,
    output logic        rx_ready
);

`ifdef ENET_RX_CRC_STRIP_EN
    localparam int LINE_N = 5;
`else
    localparam int LINE_N = 1;
`endif
    localparam int CNT_W = $clog2(LINE_N + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_NIB_PRE = 4'h5;
    localparam logic [3:0] C_NIB_SFD = 4'hD;
    localparam logic [CNT_W-1:0] C_LINE_FULL = CNT_W'(LINE_N);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [3:0] low_q, low_d;
    logic [7:0] line_q [LINE_N];
    logic [7:0] line_d [LINE_N];
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic overflow_q, overflow_d;
    logic align_err_q, align_err_d;
    logic rx_ready_q;
    logic [8:0] mem_q [DEPTH];

    logic       byte_done, frame_end, set_align;
    logic [7:0] new_byte;
    logic       push_req;
    logic [8:0] push_data;
    logic       flush, rd_en, fifo_empty, fifo_full, pop, push_ok, ovf_set;
    logic [8:0] head;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[31:1];
    assign new_byte     = {rxd, low_q};

    // Receive framing: preamble/SFD detection and nibble pairing.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        byte_done = 1'b0;
        frame_end = 1'b0;
        set_align = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv && rxd == C_NIB_PRE) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (!rx_dv)                 state_d = ST_IDLE;
                else if (rxd == C_NIB_PRE)  state_d = ST_PRE;
                else if (rxd == C_NIB_SFD)  state_d = ST_DATA_LO;
                else                        state_d = ST_DROP;
            end
            ST_DATA_LO: begin
                if (!rx_dv) begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    low_d   = rxd;
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (!rx_dv) begin
                    // Half byte is discarded; the frame still ends normally.
                    set_align = 1'b1;
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    byte_done = 1'b1;
                    state_d   = ST_DATA_LO;
                end
            end
            ST_DROP: begin
                if (!rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delay line: index 0 is newest; the oldest byte leaves only once the line is full.
    always_comb begin
        line_d    = line_q;
        count_d   = count_q;
        push_req  = 1'b0;
        push_data = 9'd0;
        if (byte_done) begin
            if (count_q == C_LINE_FULL) begin
                push_req  = 1'b1;
                push_data = {1'b0, line_q[LINE_N-1]};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            line_d[0] = new_byte;
            for (int i = 1; i < LINE_N; i++) begin
                line_d[i] = line_q[i-1];
            end
        end else if (frame_end) begin
            // Short frames that never filled the line push nothing.
            if (count_q == C_LINE_FULL) begin
                push_req  = 1'b1;
                push_data = {1'b1, line_q[LINE_N-1]};
            end
            count_d = '0;
        end
        if (flush) count_d = '0;
    end

    // FIFO control: flush beats push; a pop on a full FIFO makes room for a push.
    always_comb begin
        flush      = enet_cs & sig_w & wdata[0];
        rd_en      = enet_cs & sig_r;
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
        pop        = rd_en & ~fifo_empty;
        push_ok    = push_req & (~fifo_full | pop) & ~flush;
        ovf_set    = push_req & fifo_full & ~pop & ~flush;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            align_err_d = 1'b0;
        end else begin
            wptr_d      = wptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
            rptr_d      = rptr_q + {{DEPTH_LOG2{1'b0}}, pop};
            overflow_d  = overflow_q | ovf_set;
            align_err_d = align_err_q | set_align;
        end
    end

    // CPU read word, combinational from the FIFO head.
    always_comb begin
        head  = fifo_empty ? 9'd0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
        rdata = 32'd0;
        if (rd_en) rdata = {~fifo_empty, overflow_q, align_err_q, 20'd0, head};
    end

    // State, delay line, pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            low_q       <= 4'd0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            align_err_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            for (int i = 0; i < LINE_N; i++) line_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            low_q       <= low_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            align_err_q <= align_err_d;
            rx_ready_q  <= ~fifo_empty;
            line_q      <= line_d;
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end

    assign rx_ready = rx_ready_q;

endmodule
`default_nettype wire
